sha256_msg_padder: RTL and testbench

- Front-end feeder for the SHA-256 compression core.
- Accepts a raw message as a byte stream and applies FIPS 180-4 padding: 0x80 marker, zero fill, then the 64-bit big-endian bit length.
- Emits 512-bit blocks as sixteen 32-bit big-endian words over a valid/ready handshake, with block-start and final-word markers so the core can sequence its rounds.

---
 rtl/sha256_msg_padder.sv | 109 ++++++++++
 tb/tb_sha256_msg_padder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 padding of a byte stream into 512-bit blocks
// emitted as sixteen big-endian 32-bit words over valid/ready.
module sha256_msg_padder #(
    parameter int WORD_SIZE = 32,
    parameter int LEN_W     = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic                 end_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [WORD_SIZE-1:0] word_o,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic                 block_start_o,
    output logic                 last_word_o,
    output logic                 busy_o
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD80, ZERO, LEN, DRAIN} state_t;

    state_t               state, state_nx;
    logic [5:0]           pos;
    logic [LEN_W-1:0]     bit_len;
    logic [63:0]          len64;
    logic [23:0]          acc;
    logic [WORD_SIZE-1:0] word_q;
    logic                 valid_q, bs_q, last_q;
    logic                 ins_valid, can_absorb, fire;
    logic [7:0]           ins_byte;

    assign len64 = 64'(bit_len);
    // pos[1:0] is the accumulator fill level; the 4th byte must find room in the output register
    assign can_absorb = pos[1:0] != 2'd3 || !valid_q || word_ready_i;
    assign fire = ins_valid && can_absorb;

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx  = state;
        ins_valid = 1'b0;
        ins_byte  = byte_i;
        case (state)
            IDLE:  if (start_i) state_nx = LOAD;
            LOAD: begin
                ins_valid = byte_valid_i;
                if (end_i) state_nx = PAD80;
            end
            PAD80: begin
                ins_valid = 1'b1;
                ins_byte  = 8'h80;
                if (can_absorb) state_nx = (pos == 6'd55) ? LEN : ZERO;
            end
            ZERO: begin
                ins_valid = 1'b1;
                ins_byte  = 8'h00;
                if (can_absorb && pos == 6'd55) state_nx = LEN;
            end
            LEN: begin
                ins_valid = 1'b1;
                ins_byte  = 8'(len64 >> {~pos[2:0], 3'b000});
                if (can_absorb && pos == 6'd63) state_nx = DRAIN;
            end
            DRAIN: if (valid_q && word_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            pos     <= '0;
            bit_len <= '0;
            acc     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            bs_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                pos     <= '0;
                bit_len <= '0;
            end
            if (fire) begin
                pos <= pos + 6'd1;
                if (pos[1:0] != 2'd3) acc <= {acc[15:0], ins_byte};
            end
            if (fire && state == LOAD) bit_len <= bit_len + LEN_W'(8);
            if (fire && pos[1:0] == 2'd3) begin
                word_q  <= {acc, ins_byte};
                valid_q <= 1'b1;
                bs_q    <= pos == 6'd3;
                last_q  <= state == LEN && pos == 6'd63;
            end else if (word_ready_i) begin
                valid_q <= 1'b0;
            end
        end

    assign byte_ready_o  = state == LOAD && can_absorb;
    assign word_o        = word_q;
    assign word_valid_o  = valid_q;
    assign block_start_o = bs_q & valid_q;
    assign last_word_o   = last_q & valid_q;
    assign busy_o        = state != IDLE;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: table vectors, hand sequences and random messages
// checked against a queue-based padding model.
module tb_sha256_msg_padder;
    logic        clk = 0, rstn_i = 0, start_i = 0, end_i = 0, byte_valid_i = 0, word_ready_i = 0;
    logic [7:0]  byte_i = 0;
    logic        byte_ready_o, word_valid_o, block_start_o, last_word_o, busy_o;
    logic [31:0] word_o;

    sha256_msg_padder dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .end_i(end_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .block_start_o(block_start_o), .last_word_o(last_word_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {logic [31:0] w; logic bs; logic last;} wrec_t;
    typedef wrec_t wq_t[$];
    typedef struct {int len; logic [7:0] fill; int mode; int nwords; int idx; logic [31:0] w; logic bs; logic last;} vec_t;

    int    n_assert = 0, n_fail = 0, cyc = 0, rmode = 0;
    wq_t   got;
    logic  prev_stall = 0;
    wrec_t held;
    vec_t  tbl[8];
    logic [31:0] abc_w[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic wq_t model(input bq_t msg);
        bq_t p = msg;
        wq_t e;
        logic [63:0] bl = 64'(msg.size()) * 64'd8;
        int n;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        n = p.size() / 4;
        for (int i = 0; i < n; i++)
            e.push_back('{{p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]}, i % 16 == 0, i == n - 1});
        return e;
    endfunction

    task automatic sample();
        if (prev_stall)
            check("hold_output", {word_valid_o, block_start_o, last_word_o, word_o}, {1'b1, held.bs, held.last, held.w});
        if (word_valid_o && word_ready_i) got.push_back('{word_o, block_start_o, last_word_o});
        prev_stall = word_valid_o && !word_ready_i;
        held = '{word_o, block_start_o, last_word_o};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        word_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic run_msg(input bq_t msg, input int mode, input bit gaps, input bit combine, input bit noise);
        int  i = 0, acc = 0, guard = 0;
        bit  fire, done = 0;
        wq_t exp;
        rmode = mode;
        got.delete();
        start_i = 1;
        @(negedge clk);
        sample();
        tick();
        start_i = 0;
        check("busy_after_start", busy_o, 1);
        while (!done && guard < 5000) begin
            guard++;
            byte_valid_i = i < msg.size() && (!gaps || $urandom_range(0, 3) != 0);
            byte_i = i < msg.size() ? msg[i] : 8'($urandom);
            @(negedge clk);
            end_i = i == msg.size() || (combine && i == msg.size() - 1 && byte_valid_i && byte_ready_o);
            check("byte_ready", byte_ready_o, !(acc == 3 && word_valid_o && !word_ready_i));
            fire = byte_valid_i && byte_ready_o;
            sample();
            done = end_i;
            tick();
            end_i = 0;
            if (fire) begin
                i++;
                acc = (acc + 1) % 4;
            end
        end
        byte_valid_i = 0;
        if (!done) begin
            n_assert++; n_fail++;
            $display("FAIL load_timeout: got %0d bytes accepted expected %0d", i, msg.size());
        end
        guard = 0;
        while (1) begin
            @(negedge clk);
            sample();
            if (!busy_o) break;
            if (++guard > 5000) begin
                n_assert++; n_fail++;
                $display("FAIL drain_timeout: got busy after %0d cycles expected idle", guard);
                break;
            end
            check("byte_ready_pad", byte_ready_o, 0);
            if (noise) begin
                start_i = 1'($urandom_range(0, 1));
                end_i = 1'($urandom_range(0, 1));
                byte_valid_i = 1'($urandom_range(0, 1));
                byte_i = 8'($urandom);
            end
            tick();
            start_i = 0; end_i = 0; byte_valid_i = 0;
        end
        exp = model(msg);
        check("word_count", got.size(), exp.size());
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            check($sformatf("word[%0d]", k), got[k].w, exp[k].w);
            check($sformatf("block_start[%0d]", k), got[k].bs, exp[k].bs);
            check($sformatf("last_word[%0d]", k), got[k].last, exp[k].last);
        end
    endtask

    task automatic check_abc(input string name);
        check({name, "_count"}, got.size(), 16);
        for (int k = 0; k < got.size() && k < 16; k++)
            check($sformatf("%s_word[%0d]", name, k), {got[k].bs, got[k].last, got[k].w}, {k == 0, k == 15, abc_w[k]});
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {byte_ready_o, word_valid_o, block_start_o, last_word_o, busy_o, word_o}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t abc = '{8'h61, 8'h62, 8'h63};
        bq_t m;
        tbl[0] = '{55, 8'h41, 0, 16, 13, 32'h41414180, 1'b0, 1'b0};
        tbl[1] = '{55, 8'h41, 1, 16, 15, 32'h000001B8, 1'b0, 1'b1};
        tbl[2] = '{56, 8'h41, 0, 32, 14, 32'h80000000, 1'b0, 1'b0};
        tbl[3] = '{56, 8'h41, 2, 32, 16, 32'h00000000, 1'b1, 1'b0};
        tbl[4] = '{56, 8'h41, 0, 32, 31, 32'h000001C0, 1'b0, 1'b1};
        tbl[5] = '{0, 8'h00, 0, 16, 0, 32'h80000000, 1'b1, 1'b0};
        tbl[6] = '{0, 8'h00, 1, 16, 15, 32'h00000000, 1'b0, 1'b1};
        tbl[7] = '{64, 8'h5A, 2, 32, 31, 32'h00000200, 1'b0, 1'b1};
        for (int k = 0; k < 16; k++) abc_w[k] = 32'h0;
        abc_w[0] = 32'h61626380;
        abc_w[15] = 32'h00000018;

        #2;
        check_idle_outputs("reset_outputs");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn_i = 1;
        tick();
        check_idle_outputs("idle_after_reset");

        run_msg(abc, 0, 0, 1, 0);
        check_abc("abc");
        run_msg(abc, 1, 0, 0, 0);
        check_abc("abc_stall");

        for (int t = 0; t < 8; t++) begin
            m.delete();
            for (int k = 0; k < tbl[t].len; k++) m.push_back(tbl[t].fill);
            run_msg(m, tbl[t].mode, 0, t % 2 == 1, 0);
            check($sformatf("tbl%0d_nwords", t), got.size(), tbl[t].nwords);
            if (got.size() > tbl[t].idx)
                check($sformatf("tbl%0d_word", t), {got[tbl[t].idx].bs, got[tbl[t].idx].last, got[tbl[t].idx].w},
                      {tbl[t].bs, tbl[t].last, tbl[t].w});
        end

        for (int t = 0; t < 10; t++) begin
            m.delete();
            for (int k = 0; k < int'($urandom_range(0, 140)); k++) m.push_back(8'($urandom));
            run_msg(m, 2, 1, 1'($urandom_range(0, 1)), 1);
        end

        rmode = 0;
        start_i = 1;
        tick();
        start_i = 0;
        byte_valid_i = 1;
        for (int k = 0; k < 20; k++) begin
            byte_i = 8'(k);
            tick();
        end
        rmode = 3;
        tick();
        repeat (6) tick();
        byte_valid_i = 0;
        check("pre_reset_busy", {busy_o, word_valid_o}, 2'b11);
        #2;
        rstn_i = 0;
        #1;
        check_idle_outputs("async_reset_outputs");
        prev_stall = 0;
        rmode = 0;
        @(negedge clk);
        rstn_i = 1;
        tick();
        run_msg(abc, 0, 0, 0, 0);
        check_abc("abc_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
